// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode stage: MIPS-style opcode and funct
// constants, the decoded control bundle, the branch encoding and the
// skid-buffer state enum.
// -----------------------------------------------------------------------------
package decode_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  // SPECIAL funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Stores never touch more than a word, so the bundle only carries 4 lanes;
  // wider memories see the upper lanes tied to zero.
  localparam int STORE_LANES = 4;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_e;

  typedef struct packed {
    logic                   memtoreg;
    logic                   alusrc;
    logic                   regdst;
    logic                   regwrite;
    logic                   jump;
    logic                   link;
    logic [STORE_LANES-1:0] memwrite;
    branch_e                branch;
    logic                   md_op;     // MULT/MULTU/DIV/DIVU: starts the busy window
    logic                   hilo_rd;   // MFHI/MFLO: must wait for the busy window
    logic                   reserved;  // op/funct not in the decode table
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // True when the instruction depends on (or restarts) the HI/LO unit and so
  // has to be held back while a multiply/divide is still in flight.
  function automatic logic needs_md_idle(input ctrl_t c);
    return c.md_op | c.hilo_rd;
  endfunction

endpackage

// File: rtl/ctrl_lut.sv
// -----------------------------------------------------------------------------
// ctrl_lut
// Purely combinational instruction decoder: maps one 32-bit instruction to a
// control bundle. funct is only looked at for the SPECIAL opcode. Anything not
// in the table yields an all-zero bundle with the reserved flag set.
//
// Ports
//   instr  in  32  instruction word
//   ctrl   out     decoded control bundle (decode_pkg::ctrl_t)
// -----------------------------------------------------------------------------
module ctrl_lut
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op            = instr[31:26];
  assign funct         = instr[5:0];
  // Register/immediate fields are irrelevant to control decode.
  assign unused_fields = ^instr[25:6];

  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave a
    // bit unassigned and infer a latch.
    ctrl = CTRL_NONE;
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_SB: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 4'b0001;
      end
      OP_SH: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 4'b0011;
      end
      OP_SW: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 4'b1111;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_BEQ: ctrl.branch = BR_EQ;
      OP_BNE: ctrl.branch = BR_NE;
      OP_J:   ctrl.jump   = 1'b1;
      OP_JAL: begin
        ctrl.jump     = 1'b1;
        ctrl.link     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_SPECIAL: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
            ctrl.hilo_rd  = 1'b1;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: ctrl.md_op = 1'b1;
          FN_JR:   ; // valid, but drives no controls at this stage
          FN_JALR: begin
            ctrl.link     = 1'b1;
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
          end
          default: ctrl.reserved = 1'b1;
        endcase
      end
      default: ctrl.reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Decodes instructions at the input (ctrl_lut) and holds the decoded bundles
// in a 2-entry skid buffer (EMPTY/ONE/TWO). A multiply/divide leaving the
// buffer starts an MD_CYCLES busy window; while busy, a head entry that is
// MFHI/MFLO or another multiply/divide is held back, other ops pass.
//
// Parameters
//   BYTE_LANES  memory byte lanes (4 or 8)
//   MD_CYCLES   multiply/divide busy window in cycles (1..255)
//
// Ports
//   clk, resetn                 clock, async active-low reset
//   in_valid, in_instr, in_ready instruction input handshake (in_ready registered)
//   flush                       drop all buffered entries and same-cycle input
//   out_valid, out_ready        control-bundle output handshake
//   memtoreg, alusrc, regdst, regwrite, jump, link   head-entry controls
//   memwrite [BYTE_LANES]       store byte-lane enables
//   branch [2]                  00 none, 01 BEQ, 10 BNE
//   md_start, md_busy           multiply/divide issue pulse and busy flag
//   ri                          reserved-instruction flag (only with DECODE_RI_EN)
//
// Build option: define DECODE_RI_EN to add the ri output.
// -----------------------------------------------------------------------------
module decode_stage
  import decode_pkg::*;
#(
  parameter int BYTE_LANES = 4,
  parameter int MD_CYCLES  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic [31:0]           in_instr,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  memtoreg,
  output logic                  alusrc,
  output logic                  regdst,
  output logic                  regwrite,
  output logic                  jump,
  output logic                  link,
  output logic [BYTE_LANES-1:0] memwrite,
  output logic [1:0]            branch,
  output logic                  md_start,
  output logic                  md_busy
`ifdef DECODE_RI_EN
  ,
  output logic                  ri
`endif
);

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES);

  ctrl_t      in_ctrl;
  ctrl_t      head;
  ctrl_t      tail;
  buf_state_e state;
  buf_state_e state_nxt;
  logic [7:0] md_count;
  logic       accept;
  logic       pop;
  logic       interlock;

  ctrl_lut u_ctrl_lut (
    .instr (in_instr),
    .ctrl  (in_ctrl)
  );

  // ---------------------------------------------------------------------------
  // Handshake qualifiers. flush cancels both sides for the cycle it is high,
  // so nothing is accepted or handed downstream while the buffer is dropped.
  // ---------------------------------------------------------------------------
  assign interlock = md_busy && needs_md_idle(head);
  assign out_valid = (state != EMPTY) && !interlock && !flush;
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign md_start  = pop && head.md_op;

  // ---------------------------------------------------------------------------
  // Buffer state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !pop)      state_nxt = TWO;
          else if (!accept && pop) state_nxt = EMPTY;
        end
        TWO:     if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state is always assigned with <= so every flop samples
      // the pre-edge values regardless of statement order.
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Registered so in_ready never combinationally depends on out_ready.
      in_ready <= (state_nxt != TWO);
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage. head is always the oldest entry; tail only holds data in
  // TWO. A simultaneous accept and pop in ONE writes straight into head.
  // ---------------------------------------------------------------------------
  // NOTE: payload registers carry no reset; they are only observed through
  // state, which is reset, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    case (state)
      EMPTY: if (accept) head <= in_ctrl;
      ONE: begin
        if (accept && pop) head <= in_ctrl;
        else if (accept)   tail <= in_ctrl;
      end
      TWO:     if (pop) head <= tail;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiply/divide busy window: loads on issue, counts down, sticks at 0.
  // Flush deliberately leaves it alone: the unit is still working.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_count <= 8'd0;
    end else if (md_start) begin
      md_count <= MD_LOAD;
    end else if (md_count != 8'd0) begin
      md_count <= md_count - 8'd1;
    end
  end

  assign md_busy = (md_count != 8'd0);

  // ---------------------------------------------------------------------------
  // Outputs: head controls, forced to zero whenever nothing is offered.
  // ---------------------------------------------------------------------------
  assign memtoreg = out_valid & head.memtoreg;
  assign alusrc   = out_valid & head.alusrc;
  assign regdst   = out_valid & head.regdst;
  assign regwrite = out_valid & head.regwrite;
  assign jump     = out_valid & head.jump;
  assign link     = out_valid & head.link;
  assign branch   = out_valid ? head.branch : BR_NONE;

  always_comb begin
    memwrite = '0;
    if (out_valid) memwrite[STORE_LANES-1:0] = head.memwrite;
  end

`ifdef DECODE_RI_EN
  assign ri = out_valid & head.reserved;
`else
  logic unused_reserved;
  assign unused_reserved = head.reserved;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed bench for decode_stage (BYTE_LANES=8, MD_CYCLES=4). Stimulus pushes
// hand-computed expected bundles into a scoreboard queue on every accepted
// input; an independent monitor pops and compares on every output handshake
// and checks that controls are zero whenever out_valid is low.
// Expected bundle layout: {memtoreg, alusrc, regdst, regwrite, jump, link,
// branch[1:0], memwrite[7:0]}.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  localparam int BYTE_LANES = 8;
  localparam int MD_CYCLES  = 4;

  // Instructions
  localparam logic [31:0] I_LW   = 32'h8C410004;
  localparam logic [31:0] I_LBU  = 32'h90220000;
  localparam logic [31:0] I_SH   = 32'hA4220002;
  localparam logic [31:0] I_SB   = 32'hA0220001;
  localparam logic [31:0] I_SW   = 32'hAC220000;
  localparam logic [31:0] I_ADDU = 32'h00221821;
  localparam logic [31:0] I_SLL0 = 32'h00000000;
  localparam logic [31:0] I_DIV  = 32'h0022001A;
  localparam logic [31:0] I_MULT = 32'h00220018;
  localparam logic [31:0] I_MFHI = 32'h00001810;
  localparam logic [31:0] I_ADDI = 32'h20210005;
  localparam logic [31:0] I_ORI  = 32'h34210001;
  localparam logic [31:0] I_ANDI = 32'h30210001;
  localparam logic [31:0] I_LUI  = 32'h3C011234;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_JALR = 32'h0020F809;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_RSOP = 32'hFC000000;
  localparam logic [31:0] I_RSFN = 32'h00000001;

  // Hand-computed expected bundles
  localparam logic [15:0] E_LOAD  = 16'b110100_00_00000000;
  localparam logic [15:0] E_SH    = 16'b010000_00_00000011;
  localparam logic [15:0] E_SB    = 16'b010000_00_00000001;
  localparam logic [15:0] E_SW    = 16'b010000_00_00001111;
  localparam logic [15:0] E_RTYPE = 16'b001100_00_00000000;
  localparam logic [15:0] E_IMM   = 16'b010100_00_00000000;
  localparam logic [15:0] E_BEQ   = 16'b000000_01_00000000;
  localparam logic [15:0] E_BNE   = 16'b000000_10_00000000;
  localparam logic [15:0] E_J     = 16'b000010_00_00000000;
  localparam logic [15:0] E_JAL   = 16'b000111_00_00000000;
  localparam logic [15:0] E_JALR  = 16'b001101_00_00000000;
  localparam logic [15:0] E_ZERO  = 16'b000000_00_00000000;

  typedef struct {
    logic [31:0] instr;
    logic [15:0] ctrl;
    logic        ri;
  } exp_t;

  logic                  clk;
  logic                  resetn;
  logic                  in_valid;
  logic [31:0]           in_instr;
  logic                  in_ready;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic                  memtoreg, alusrc, regdst, regwrite, jump, link;
  logic [BYTE_LANES-1:0] memwrite;
  logic [1:0]            branch;
  logic                  md_start;
  logic                  md_busy;
  logic                  act_ri;
  logic [15:0]           act_ctrl;

  exp_t sb_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   md_start_cnt = 0;

  decode_stage #(
    .BYTE_LANES (BYTE_LANES),
    .MD_CYCLES  (MD_CYCLES)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .memtoreg  (memtoreg),
    .alusrc    (alusrc),
    .regdst    (regdst),
    .regwrite  (regwrite),
    .jump      (jump),
    .link      (link),
    .memwrite  (memwrite),
    .branch    (branch),
    .md_start  (md_start),
    .md_busy   (md_busy)
`ifdef DECODE_RI_EN
    ,
    .ri        (act_ri)
`endif
  );

`ifndef DECODE_RI_EN
  assign act_ri = 1'b0;
`endif

  assign act_ctrl = {memtoreg, alusrc, regdst, regwrite, jump, link, branch, memwrite};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=timeout required=event (t=%0t)", name, $time);
  endtask

  // Expected ri only exists when the feature is built in.
  function automatic logic eff_ri(input logic r);
`ifdef DECODE_RI_EN
    return r;
`else
    return 1'b0 & r;
`endif
  endfunction

  // Present one instruction; called between edges. Returns 1 ns after the
  // edge that accepted it, with in_valid dropped.
  task automatic send(input logic [31:0] instr, input logic [15:0] ectrl, input logic eri);
    exp_t e;
    int   guard;
    guard    = 0;
    in_valid = 1'b1;
    in_instr = instr;
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      timeout_fail("send_in_ready");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.instr = instr;
      e.ctrl  = ectrl;
      e.ri    = eff_ri(eri);
      sb_q.push_back(e);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (md_busy && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (md_busy) timeout_fail("wait_md_idle");
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (md_start) md_start_cnt++;
      if (!out_valid) begin
        check("idle_controls_zero", {15'd0, act_ri, act_ctrl}, 32'd0);
      end else if (resetn && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual=%h required=none", act_ctrl);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("bundle_%h", e.instr), {15'd0, act_ri, act_ctrl},
                {15'd0, e.ri, e.ctrl});
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    int n0;
    int held;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_md_busy", {31'd0, md_busy}, 32'd0);
    check("rst_controls", {15'd0, act_ri, act_ctrl}, 32'd0);
    #19;
    resetn = 1'b1;
    #1;
    check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("in_ready_first_edge", {31'd0, in_ready}, 32'd1);

    // LW with 1-cycle latency
    out_ready = 1'b1;
    send(I_LW, E_LOAD, 1'b0);
    check("lw_latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("lw_memwrite", {24'd0, memwrite}, 32'd0);
    drain();

    // Stores on an 8-lane memory, then a mix of decode patterns
    send(I_SH, E_SH, 1'b0);
    send(I_SB, E_SB, 1'b0);
    send(I_SW, E_SW, 1'b0);
    send(I_LBU, E_LOAD, 1'b0);
    send(I_SLL0, E_RTYPE, 1'b0);
    send(I_LUI, E_IMM, 1'b0);
    send(I_BEQ, E_BEQ, 1'b0);
    send(I_BNE, E_BNE, 1'b0);
    send(I_J, E_J, 1'b0);
    send(I_JAL, E_JAL, 1'b0);
    send(I_JALR, E_JALR, 1'b0);
    send(I_JR, E_ZERO, 1'b0);
    drain();

    // Backpressure: third input stalls, order preserved on release
    out_ready = 1'b0;
    send(I_ADDI, E_IMM, 1'b0);
    send(I_BEQ, E_BEQ, 1'b0);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    fork
      send(I_BNE, E_BNE, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        check("stall_hold_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
    join
    drain();

    // DIV then MFHI: MFHI held for MD_CYCLES cycles, one md_start
    n0 = md_start_cnt;
    send(I_DIV, E_ZERO, 1'b0);
    send(I_MFHI, E_RTYPE, 1'b0);
    check("md_busy_after_div", {31'd0, md_busy}, 32'd1);
    held = 0;
    while (held < 20) begin
      @(negedge clk);
      if (out_valid) break;
      held++;
    end
    check("mfhi_held_cycles", held, MD_CYCLES);
    drain();
    check("md_start_once_a", md_start_cnt - n0, 1);
    wait_idle();

    // DIV, ADDU, MFHI: ADDU passes while busy
    n0 = md_start_cnt;
    send(I_DIV, E_ZERO, 1'b0);
    send(I_ADDU, E_RTYPE, 1'b0);
    @(negedge clk);
    check("addu_passes_valid", {31'd0, out_valid}, 32'd1);
    check("addu_passes_busy", {31'd0, md_busy}, 32'd1);
    send(I_MFHI, E_RTYPE, 1'b0);
    drain();
    check("md_start_once_b", md_start_cnt - n0, 1);
    wait_idle();

    // Flush in TWO with a pending input; md counter keeps running
    send(I_DIV, E_ZERO, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(I_ADDI, E_IMM, 1'b0);
    send(I_ORI, E_IMM, 1'b0);
    check("flush_pre_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_instr = I_ANDI;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_md_busy_kept", {31'd0, md_busy}, 32'd1);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("flush_md_counted_down", {31'd0, md_busy}, 32'd0);
    check("flush_input_dropped", {31'd0, out_valid}, 32'd0);

    // Reserved op / funct: passed downstream with controls 0
    send(I_RSOP, E_ZERO, 1'b1);
    send(I_RSFN, E_ZERO, 1'b1);
    send(I_ADDU, E_RTYPE, 1'b0);
    drain();

    // Reset asserted mid-busy with an entry buffered
    n0 = md_start_cnt;
    send(I_MULT, E_ZERO, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(I_ADDU, E_RTYPE, 1'b0);
    check("pre_reset_busy", {31'd0, md_busy}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    sb_q.delete();
    check("reset_md_busy", {31'd0, md_busy}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_md_start", {31'd0, md_start}, 32'd0);
    check("reset_controls", {15'd0, act_ri, act_ctrl}, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("no_residual_md_start", md_start_cnt - n0, 1);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter BYTE_LANES, default 4, SHALL set the memory byte-lane count; legal values are 4 and 8.
REQ-002 Parameter MD_CYCLES, default 32, SHALL set the multiply/divide busy window in cycles; legal range is 1..255.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 resetn  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 in_valid  in  1; in_instr  in  32; in_ready  out  1 -- SHALL form the instruction input handshake.
REQ-006 flush  in  1  SHALL discard all buffered instructions.
REQ-007 out_valid  out  1; out_ready  in  1 -- SHALL form the control-bundle output handshake.
REQ-008 memtoreg, alusrc, regdst, regwrite, jump, link  out  1 each -- SHALL be the decoded controls of the head entry.
REQ-009 memwrite  out  BYTE_LANES  SHALL be the store byte-lane enables.
REQ-010 branch  out  2  SHALL encode 00 none, 01 BEQ, 10 BNE.
REQ-011 md_start  out  1; md_busy  out  1 -- SHALL report multiply/divide issue and busy state.
REQ-012 ri  out  1  SHALL flag a reserved instruction (present only with DECODE_RI_EN).

Function
REQ-013 Decode SHALL use op = instr[31:26] and funct = instr[5:0]; funct is consulted only when op = 000000.
REQ-014 Loads (LB, LBU, LH, LHU, LW) SHALL set memtoreg=1, alusrc=1, regwrite=1, regdst=0.
REQ-015 Store lane enables SHALL be: SB = lane 0; SH = lanes 1:0; SW = lanes 3:0; upper lanes stay 0 when BYTE_LANES=8; stores set alusrc=1 and regwrite=0.
REQ-016 ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI and LUI SHALL set alusrc=1, regwrite=1, regdst=0.
REQ-017 SPECIAL ALU/shift ops, MFHI and MFLO SHALL set regwrite=1, regdst=1; MULT, MULTU, DIV, DIVU and JR SHALL set regwrite=0.
REQ-018 J SHALL set jump=1; JAL SHALL set jump=1, link=1, regwrite=1; JALR SHALL set link=1, regwrite=1, regdst=1.
REQ-019 An unlisted op or funct SHALL drive all controls 0.
REQ-020 Buffering SHALL be a 2-entry skid buffer with states EMPTY, ONE, TWO; out_valid is 0 in EMPTY; in_ready = (state != TWO), registered.
REQ-021 Transitions: EMPTY->ONE on accept; ONE->TWO on accept without pop; TWO->ONE on pop; simultaneous accept and pop SHALL hold the state.
REQ-022 Input-to-output latency SHALL be 1 cycle when EMPTY; entries SHALL leave in strict FIFO order.
REQ-023 On pop of a MULT, MULTU, DIV or DIVU, md_start SHALL pulse for 1 cycle and an 8-bit counter SHALL load MD_CYCLES.
REQ-024 md_busy SHALL equal (counter != 0); the counter decrements by 1 per cycle and saturates at 0.
REQ-025 While md_busy=1 and the head entry is MFHI, MFLO or a multiply/divide op, out_valid SHALL be held 0 (interlock); other ops pass.
REQ-026 flush SHALL force state EMPTY next cycle, drop any same-cycle input, and leave the md counter untouched.
REQ-027 Output controls SHALL be 0 whenever out_valid=0.

Reset
REQ-028 While resetn=0: state EMPTY, counter 0, every output 0 including in_ready.
REQ-029 in_ready SHALL be 1 on the first clk edge after resetn deasserts.
REQ-030 A reset asserted mid-busy or mid-transfer SHALL abort it with no residual pulse on md_start.

Configuration
REQ-031 With macro DECODE_RI_EN defined, ri SHALL be 1 for an unlisted op/funct on a valid head entry; the bundle is still passed downstream with all controls 0.
REQ-032 Without DECODE_RI_EN, the ri port and its logic SHALL be absent.

Structure
REQ-033 Package decode_pkg SHALL hold the opcode and funct constants, the control-bundle struct and the buffer-state enum.
REQ-034 Combinational decode SHALL live in sub-module ctrl_lut (instr in, bundle out), instantiated once at the input; entries store the decoded bundle.

Verification
REQ-035 LW 0x8C410004, out_ready=1 -> next cycle out_valid=1, memtoreg=1, alusrc=1, regwrite=1, memwrite=0000.
REQ-036 SH then SB with BYTE_LANES=8 -> memwrite 00000011, then 00000001.
REQ-037 out_ready=0, three back-to-back inputs -> third input stalled (in_ready=0); release -> FIFO order preserved.
REQ-038 DIV then MFHI, MD_CYCLES=4 -> md_start pulses once; MFHI out_valid held for 4 cycles; ADDU inserted between them passes.
REQ-039 flush with state TWO and in_valid=1 -> next cycle out_valid=0 and input dropped; md_busy continues counting.
REQ-040 op 111111 with DECODE_RI_EN -> ri=1, all controls 0; resetn pulsed low mid-busy -> md_busy=0 and all outputs 0 immediately.
